// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM encoding, default timing and keyboard command bytes.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_SEND,
    ST_ACK,
    ST_WAIT_IDLE
  } tx_state_e;

  localparam int CNT_W                  = 20;
  localparam int DEFAULT_INHIBIT_CYCLES = 5000;
  localparam int DEFAULT_TIMEOUT_CYCLES = 750000;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] ACK_BYTE     = 8'hFA;

  // Pull-down request for frame bit idx: data LSB first, odd parity, then released stop bit.
  function automatic logic frame_bit_oe(input logic [7:0] data, input logic [3:0] idx);
    if (idx < 4'd8) return ~data[idx[2:0]];
    if (idx == 4'd8) return ^data;
    return 1'b0;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Three-flop synchronizer for the PS/2 clock and data lines plus a clock falling-edge strobe.
module ps2_line_sync (
  input  logic clk,
  input  logic clr,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic clk_sync_o,
  output logic data_sync_o,
  output logic clk_fall_o
);

  logic [2:0] clk_sync_q;
  logic [2:0] data_sync_q;

  // Idle PS/2 lines float high, so reset to 1 to avoid a false edge after reset.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      clk_sync_q  <= 3'b111;
      data_sync_q <= 3'b111;
    end else begin
      clk_sync_q  <= {clk_sync_q[1:0], ps2_clk_i};
      data_sync_q <= {data_sync_q[1:0], ps2_data_i};
    end
  end

  assign clk_sync_o  = clk_sync_q[2];
  assign data_sync_o = data_sync_q[2];
  assign clk_fall_o  = clk_sync_q[2] & ~clk_sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, device-clocked frame shift, ACK check, watchdog.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEFAULT_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam logic [CNT_W-1:0] INHIBIT_LOAD = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

  logic clk_s, data_s, clk_fall;

  ps2_line_sync u_sync (
    .clk         (clk),
    .clr         (clr),
    .ps2_clk_i   (ps2_clk_in),
    .ps2_data_i  (ps2_data_in),
    .clk_sync_o  (clk_s),
    .data_sync_o (data_s),
    .clk_fall_o  (clk_fall)
  );

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_q, bit_d;
  logic [7:0]       byte_q, byte_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             done_q, done_d;
  logic             error_q, error_d;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    error_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (tx_valid && tx_ready) begin
          byte_d   = tx_data;
          cnt_d    = INHIBIT_LOAD;
          clk_oe_d = 1'b1;
          state_d  = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        cnt_d = cnt_q - 1'b1;
        // Start bit overlaps the final inhibit cycle so the device sees it as the clock releases.
        if (cnt_q == CNT_W'(1)) data_oe_d = 1'b1;
        if (cnt_q == '0) begin
          clk_oe_d = 1'b0;
          cnt_d    = TIMEOUT_LOAD;
          bit_d    = '0;
          state_d  = ST_SEND;
        end
      end
      ST_SEND: begin
        cnt_d = cnt_q - 1'b1;
        if (clk_fall) begin
          data_oe_d = frame_bit_oe(byte_q, bit_q);
          bit_d     = bit_q + 1'b1;
          if (bit_q == 4'd9) state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        cnt_d = cnt_q - 1'b1;
        if (clk_fall) begin
          if (data_s) begin
            error_d   = 1'b1;
            data_oe_d = 1'b0;
            state_d   = ST_IDLE;
          end else begin
            state_d = ST_WAIT_IDLE;
          end
        end
      end
      ST_WAIT_IDLE: begin
        cnt_d = cnt_q - 1'b1;
        if (clk_s && data_s) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase

    // Watchdog expiry loses to a completion in the same cycle so done and error never coincide.
    if ((state_q == ST_SEND || state_q == ST_ACK || state_q == ST_WAIT_IDLE) &&
        cnt_q == '0 && !done_d && !error_d) begin
      error_d   = 1'b1;
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      state_d   = ST_IDLE;
    end
  end

  assign tx_ready    = (state_q == ST_IDLE);
  assign busy        = ~tx_ready;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign done        = done_q;
  assign error       = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-collector line model, device-clocked frame reader, scoreboard of expected frames.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 20;
  localparam int TMO  = 200;
  localparam int HALF = 6;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2_clk_line, ps2_data_line;
  logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, error;

  assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .clr         (clr),
    .ps2_clk_in  (ps2_clk_line),
    .ps2_data_in (ps2_data_line),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] bits;
    bit         ack;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0, n_pass = 0;
  int cyc = 0, acc_cnt = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0;
  logic evt_clk_oe = 1'b0, evt_data_oe = 1'b0, evt_ready = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_valid && tx_ready && !clr) acc_cnt <= acc_cnt + 1;
  end

  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (error) err_cnt <= err_cnt + 1;
    if (done && error) both_cnt <= both_cnt + 1;
    if (done || error) begin
      evt_clk_oe  <= ps2_clk_oe;
      evt_data_oe <= ps2_data_oe;
      evt_ready   <= tx_ready;
    end
  end

  // Frame bits as the device should read them: data LSB first, odd parity, stop=1.
  function automatic logic [9:0] exp_bits(input logic [7:0] b);
    return {1'b1, ~^b, b};
  endfunction

  task automatic start_tx(input logic [7:0] b, input bit ack, input bit push, output int t);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    for (int i = 0; i < 400 && !tx_ready; i++) @(negedge clk);
    t = cyc;
    if (push) exp_q.push_back('{bits: exp_bits(b), ack: ack});
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic dev_full_edge();
    repeat (HALF) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (HALF) @(negedge clk);
    dev_clk_low = 1'b0;
  endtask

  // Device side: wait for request-to-send, clock 10 bits reading on rising edges, then the ACK edge.
  task automatic dev_frame(input bit ack, output logic [9:0] got, output bit ok);
    ok  = 1'b0;
    got = '0;
    for (int i = 0; i < INH + 40; i++) begin
      @(negedge clk);
      if (ps2_clk_line && !ps2_data_line) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      for (int b = 0; b < 10; b++) begin
        dev_full_edge();
        @(negedge clk);
        got[b] = ps2_data_line;
      end
      repeat (2) @(negedge clk);
      dev_data_low = ack;
      dev_full_edge();
      repeat (2) @(negedge clk);
      dev_data_low = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({tx_ready, busy, ps2_clk_oe, ps2_data_oe, done, error} !== 6'b100000)
      $display("FAIL reset_hold: got %b want 100000", {tx_ready, busy, ps2_clk_oe, ps2_data_oe, done, error});
    else n_pass++;
    clr = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({tx_ready, busy, ps2_clk_oe, ps2_data_oe, done, error} !== 6'b100000)
      $display("FAIL reset_release: got %b want 100000", {tx_ready, busy, ps2_clk_oe, ps2_data_oe, done, error});
    else n_pass++;
    $display("reset: outputs idle");
  endtask

  task automatic test_send_ed();
    int t, hi, fd, rel, d0, e0;
    logic [9:0] got;
    bit ok;
    exp_t e;
    d0 = done_cnt; e0 = err_cnt;
    start_tx(CMD_SET_LEDS, 1'b1, 1'b1, t);
    n_checks++;
    if (ps2_clk_oe !== 1'b1 || cyc != t + 1)
      $display("FAIL inh_start: got oe=%b cyc=%0d want oe=1 cyc=%0d", ps2_clk_oe, cyc, t + 1);
    else n_pass++;
    hi = 0; fd = -1; rel = -1;
    for (int i = 0; i < INH + 10; i++) begin
      if (ps2_data_oe && fd < 0) fd = cyc;
      if (!ps2_clk_oe) begin
        rel = cyc;
        break;
      end
      hi++;
      @(negedge clk);
    end
    n_checks++;
    if (hi != INH) $display("FAIL inh_len: got %0d want %0d", hi, INH); else n_pass++;
    n_checks++;
    if (fd != t + INH) $display("FAIL start_bit_time: got %0d want %0d", fd, t + INH); else n_pass++;
    n_checks++;
    if (rel != t + INH + 1 || ps2_data_oe !== 1'b1)
      $display("FAIL clk_release: got cyc=%0d data_oe=%b want cyc=%0d data_oe=1", rel, ps2_data_oe, t + INH + 1);
    else n_pass++;
    dev_frame(1'b1, got, ok);
    n_checks++;
    if (exp_q.size() == 0 || !ok) $display("FAIL ed_frame: got ok=%b q=%0d want ok=1 q>0", ok, exp_q.size());
    else begin
      e = exp_q.pop_front();
      if (got !== e.bits) $display("FAIL ed_frame: got %b want %b", got, e.bits); else n_pass++;
    end
    n_checks++;
    if (got !== 10'h3ED) $display("FAIL ed_bits: got %b want %b", got, 10'h3ED); else n_pass++;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || error) break;
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if (done_cnt - d0 != 1 || err_cnt - e0 != 0)
      $display("FAIL ed_result: got done=%0d err=%0d want done=1 err=0", done_cnt - d0, err_cnt - e0);
    else n_pass++;
    $display("tx 0x%h: device read %b, done=%0d", CMD_SET_LEDS, got, done_cnt - d0);
  endtask

  task automatic test_parity();
    logic [7:0] bytes [3];
    logic       par [3];
    int t, d0;
    logic [9:0] got;
    bit ok;
    exp_t e;
    bytes[0] = 8'h00; bytes[1] = 8'h01; bytes[2] = 8'hFF;
    par[0] = 1'b1; par[1] = 1'b0; par[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      d0 = done_cnt;
      start_tx(bytes[k], 1'b1, 1'b1, t);
      dev_frame(1'b1, got, ok);
      n_checks++;
      if (exp_q.size() == 0 || !ok) $display("FAIL par_frame_%0d: got ok=%b q=%0d want ok=1 q>0", k, ok, exp_q.size());
      else begin
        e = exp_q.pop_front();
        if (got !== e.bits) $display("FAIL par_frame_%0d: got %b want %b", k, got, e.bits); else n_pass++;
      end
      n_checks++;
      if (got[8] !== par[k]) $display("FAIL par_bit_%0d: got %b want %b", k, got[8], par[k]); else n_pass++;
      n_checks++;
      if (got[9] !== 1'b1) $display("FAIL par_stop_%0d: got %b want 1", k, got[9]); else n_pass++;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (done || error) break;
      end
      repeat (3) @(negedge clk);
      n_checks++;
      if (done_cnt - d0 != 1) $display("FAIL par_done_%0d: got %0d want 1", k, done_cnt - d0); else n_pass++;
      $display("tx 0x%h: parity bit %b", bytes[k], got[8]);
    end
  endtask

  task automatic test_nack();
    int t, d0, e0;
    logic [9:0] got;
    bit ok;
    exp_t e;
    d0 = done_cnt; e0 = err_cnt;
    start_tx(CMD_RESET, 1'b0, 1'b1, t);
    dev_frame(1'b0, got, ok);
    repeat (5) @(negedge clk);
    n_checks++;
    if (exp_q.size() == 0 || !ok) $display("FAIL nack_frame: got ok=%b q=%0d want ok=1 q>0", ok, exp_q.size());
    else begin
      e = exp_q.pop_front();
      if (got !== e.bits) $display("FAIL nack_frame: got %b want %b", got, e.bits); else n_pass++;
      n_checks++;
      if (done_cnt - d0 != (e.ack ? 1 : 0) || err_cnt - e0 != (e.ack ? 0 : 1))
        $display("FAIL nack_result: got done=%0d err=%0d want done=0 err=1", done_cnt - d0, err_cnt - e0);
      else n_pass++;
    end
    n_checks++;
    if ({evt_clk_oe, evt_data_oe, evt_ready} !== 3'b001)
      $display("FAIL nack_lines: got clk_oe,data_oe,ready=%b want 001", {evt_clk_oe, evt_data_oe, evt_ready});
    else n_pass++;
    $display("tx 0x%h: no ack, error=%0d", CMD_RESET, err_cnt - e0);
  endtask

  task automatic test_timeout();
    int t, ecyc;
    logic lines;
    ecyc = -1; lines = 1'b1;
    start_tx(CMD_ENABLE, 1'b1, 1'b0, t);
    for (int i = 0; i < INH + TMO + 100; i++) begin
      @(negedge clk);
      if (error) begin
        ecyc  = cyc;
        lines = ps2_clk_oe | ps2_data_oe | ~tx_ready;
        break;
      end
    end
    n_checks++;
    if (ecyc < t + INH + 199 || ecyc > t + INH + 203)
      $display("FAIL timeout_time: got %0d want %0d..%0d", ecyc, t + INH + 199, t + INH + 203);
    else n_pass++;
    n_checks++;
    if (lines !== 1'b0) $display("FAIL timeout_lines: got held=%b want 0", lines); else n_pass++;
    repeat (2) @(negedge clk);
    $display("tx 0x%h: silent device, error at accept+%0d", CMD_ENABLE, ecyc - t);
  endtask

  task automatic test_reset_mid();
    int t, d0, e0;
    logic [9:0] got;
    bit ok;
    exp_t e;
    ok = 1'b0;
    start_tx(CMD_ENABLE, 1'b1, 1'b0, t);
    for (int i = 0; i < INH + 40; i++) begin
      @(negedge clk);
      if (ps2_clk_line && !ps2_data_line) begin
        ok = 1'b1;
        break;
      end
    end
    for (int b = 0; b < 3; b++) dev_full_edge();
    repeat (HALF) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (HALF - 1) @(negedge clk);
    n_checks++;
    if (!ok || ps2_data_oe !== 1'b1 || busy !== 1'b1)
      $display("FAIL mid_bit3: got ok=%b data_oe=%b busy=%b want 1 1 1", ok, ps2_data_oe, busy);
    else n_pass++;
    d0 = done_cnt; e0 = err_cnt;
    #2 clr = 1'b1;
    #1;
    n_checks++;
    if ({ps2_clk_oe, ps2_data_oe, tx_ready, busy} !== 4'b0010)
      $display("FAIL mid_clr: got %b want 0010", {ps2_clk_oe, ps2_data_oe, tx_ready, busy});
    else n_pass++;
    dev_clk_low = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (done_cnt != d0 || err_cnt != e0)
      $display("FAIL mid_no_pulse: got done=%0d err=%0d want 0 0", done_cnt - d0, err_cnt - e0);
    else n_pass++;
    $display("tx 0x%h: aborted by clr after 4 edges", CMD_ENABLE);
    d0 = done_cnt;
    start_tx(CMD_ENABLE, 1'b1, 1'b1, t);
    dev_frame(1'b1, got, ok);
    n_checks++;
    if (exp_q.size() == 0 || !ok) $display("FAIL resend_frame: got ok=%b q=%0d want ok=1 q>0", ok, exp_q.size());
    else begin
      e = exp_q.pop_front();
      if (got !== e.bits) $display("FAIL resend_frame: got %b want %b", got, e.bits); else n_pass++;
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || error) break;
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (done_cnt - d0 != 1) $display("FAIL resend_done: got %0d want 1", done_cnt - d0); else n_pass++;
    $display("tx 0x%h: resent after clr, device read %b", CMD_ENABLE, got);
  endtask

  task automatic test_back_to_back();
    int a0, d0;
    logic [9:0] got;
    bit ok, seen;
    exp_t e;
    a0 = acc_cnt; d0 = done_cnt; seen = 1'b0;
    @(negedge clk);
    tx_data  = CMD_SET_LEDS;
    tx_valid = 1'b1;
    for (int i = 0; i < 40 && !tx_ready; i++) @(negedge clk);
    exp_q.push_back('{bits: exp_bits(CMD_SET_LEDS), ack: 1'b1});
    @(negedge clk);
    tx_data = CMD_ENABLE;
    dev_frame(1'b1, got, ok);
    n_checks++;
    if (exp_q.size() == 0 || !ok) $display("FAIL b2b_frame1: got ok=%b q=%0d want ok=1 q>0", ok, exp_q.size());
    else begin
      e = exp_q.pop_front();
      if (got !== e.bits) $display("FAIL b2b_frame1: got %b want %b", got, e.bits); else n_pass++;
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!seen || tx_ready !== 1'b1 || acc_cnt - a0 != 1)
      $display("FAIL b2b_done_cycle: got seen=%b ready=%b acc=%0d want 1 1 1", seen, tx_ready, acc_cnt - a0);
    else n_pass++;
    exp_q.push_back('{bits: exp_bits(CMD_ENABLE), ack: 1'b1});
    @(negedge clk);
    n_checks++;
    if (ps2_clk_oe !== 1'b1 || acc_cnt - a0 != 2)
      $display("FAIL b2b_second_accept: got clk_oe=%b acc=%0d want 1 2", ps2_clk_oe, acc_cnt - a0);
    else n_pass++;
    tx_valid = 1'b0;
    $display("tx 0x%h then 0x%h: second accepted in done cycle", CMD_SET_LEDS, CMD_ENABLE);
    dev_frame(1'b1, got, ok);
    n_checks++;
    if (exp_q.size() == 0 || !ok) $display("FAIL b2b_frame2: got ok=%b q=%0d want ok=1 q>0", ok, exp_q.size());
    else begin
      e = exp_q.pop_front();
      if (got !== e.bits) $display("FAIL b2b_frame2: got %b want %b", got, e.bits); else n_pass++;
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || error) break;
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (done_cnt - d0 != 2 || acc_cnt - a0 != 2)
      $display("FAIL b2b_totals: got done=%0d acc=%0d want 2 2", done_cnt - d0, acc_cnt - a0);
    else n_pass++;
    n_checks++;
    if (both_cnt != 0) $display("FAIL done_error_overlap: got %0d want 0", both_cnt); else n_pass++;
    $display("tx 0x%h: device read %b", CMD_ENABLE, got);
  endtask

  initial begin
    test_reset();
    test_send_ed();
    test_parity();
    test_nack();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL sb_leftover: got %0d want 0", exp_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got cyc=%0d want finish before bound", cyc);
    $fatal(1, "simulation bound exceeded");
  end

endmodule
